// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding and command opcodes.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_STROBE  = 3'd1,
    WR_RELEASE = 3'd2,
    RD_WAIT    = 3'd3,
    RD_CAPTURE = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Width of the strobe-timing down-counter (pulse lengths 1..15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to
// the requester that did not win last time.
module sram_rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // One-hot grant selection.
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between two single-word command requesters.
// Generates active-low strobe timing, drives the data bus only while writing,
// and returns read data with a one-cycle done pulse to the command owner.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDRESS_LINES      = 8,
  parameter int DATA_WIDTH         = 8,
  parameter int READ_WAIT_CYCLES   = 2,
  parameter int WRITE_PULSE_CYCLES = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_req0Valid,
  input  logic                     i_req0Write,
  input  logic [ADDRESS_LINES-1:0] i_req0Address,
  input  logic [DATA_WIDTH-1:0]    i_req0WriteData,
  output logic                     o_req0Ready,
  output logic                     o_req0Done,
  output logic [DATA_WIDTH-1:0]    o_req0ReadData,
  input  logic                     i_req1Valid,
  input  logic                     i_req1Write,
  input  logic [ADDRESS_LINES-1:0] i_req1Address,
  input  logic [DATA_WIDTH-1:0]    i_req1WriteData,
  output logic                     o_req1Ready,
  output logic                     o_req1Done,
  output logic [DATA_WIDTH-1:0]    o_req1ReadData,
  output logic                     o_read,
  output logic                     o_write,
  output logic [ADDRESS_LINES-1:0] o_address,
  inout  wire  [DATA_WIDTH-1:0]    io_data,
  output logic                     o_busy
);

  // Counter preloads: the counter reaches zero on the last strobe-low cycle.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_PULSE_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_LINES-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     owner_q, owner_d;
  logic                     last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
  logic [1:0]               grant;
  logic                     accept;
  logic                     in_done;
  logic                     drive_bus;
  op_e                      req_op;

  sram_rr_arbiter2 u_arb (
    .i_valid      ({i_req1Valid, i_req0Valid}),
    .i_last_grant (last_grant_q),
    .o_grant      (grant)
  );

  // Ready is offered only in IDLE to the granted requester; reset suppresses it.
  assign o_req0Ready = (state_q == IDLE) & grant[0] & ~i_reset;
  assign o_req1Ready = (state_q == IDLE) & grant[1] & ~i_reset;
  assign accept      = o_req0Ready | o_req1Ready;

  assign in_done     = ((state_q == WR_RELEASE) | (state_q == RD_CAPTURE)) & ~i_reset;
  assign o_req0Done  = in_done & ~owner_q;
  assign o_req1Done  = in_done &  owner_q;

  assign o_read      = ~(state_q == RD_WAIT);
  assign o_write     = ~(state_q == WR_STROBE);
  assign o_busy      = (state_q != IDLE);
  assign o_address   = addr_q;
  assign o_req0ReadData = rdata0_q;
  assign o_req1ReadData = rdata1_q;

  // The bus is held through the release cycle to give the SRAM data hold time.
  assign drive_bus   = (state_q == WR_STROBE) | (state_q == WR_RELEASE);
  assign io_data     = drive_bus ? wdata_q : {DATA_WIDTH{1'bz}};

  assign req_op      = grant[1] ? op_e'(i_req1Write) : op_e'(i_req0Write);

  // Next-state, command latch and read-capture logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant[1];
          last_grant_d = grant[1];
          addr_d       = grant[1] ? i_req1Address   : i_req0Address;
          wdata_d      = grant[1] ? i_req1WriteData : i_req0WriteData;
          if (req_op == OP_WRITE) begin
            state_d = WR_STROBE;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      WR_STROBE: begin
        if (cnt_q == '0) state_d = WR_RELEASE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR_RELEASE: state_d = IDLE;
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RD_CAPTURE;
          if (owner_q) rdata1_d = io_data;
          else         rdata0_d = io_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_CAPTURE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Control and visible registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Internal datapath registers, only meaningful after an accept.
  always_ff @(posedge i_clock) begin
    cnt_q   <= cnt_d;
    wdata_q <= wdata_d;
    owner_q <= owner_d;
  end

endmodule
